// File: rtl/rr_decode_arbiter.sv
// Four-requester round-robin arbiter with one-hot registered grant, owner release
// via done/req drop, and an optional hold-timeout that forces rotation.
module rr_decode_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          idx_q, idx_d;
    logic [3:0]          gnt_q, gnt_d;
    logic                valid_q, valid_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;

    logic [1:0]          cand;
    logic [1:0]          winner;
    logic                any_req;
    logic                timeout;

    function automatic logic [3:0] dec2to4(input logic [1:0] sel);
        dec2to4      = '0;
        dec2to4[sel] = 1'b1;
    endfunction

    // First set request scanning upward from the priority pointer, wrapping mod 4.
    always_comb begin
        cand    = '0;
        winner  = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!any_req && req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    assign timeout = (MAX_HOLD != 0) && (cnt_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    idx_d   = winner;
                    gnt_d   = dec2to4(winner);
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!req[idx_q] || done || timeout) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    // Saturate so an unlimited hold never wraps the counter.
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboard bench: a request/owner-level reference model pushes expected grants,
// a negedge monitor pops and compares them and checks grant invariants.
module tb_rr_decode_arbiter;

    localparam int MH_A = 4;
    localparam int MH_B = 0;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_a = '0, req_b = '0;
    logic       done_a = 1'b0, done_b = 1'b0;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic       v_a, v_b;

    int checks = 0;
    int passes = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    int m_own[2];
    int m_ptr[2];
    int m_held[2];

    always #5 clk = ~clk;

    rr_decode_arbiter #(.MAX_HOLD(MH_A), .HOLD_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .done(done_a),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(v_a)
    );

    rr_decode_arbiter #(.MAX_HOLD(MH_B), .HOLD_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .done(done_b),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(v_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t model_out(input int u);
        exp_t e;
        e.v   = (m_own[u] >= 0);
        e.idx = e.v ? 2'(m_own[u]) : 2'd0;
        e.gnt = e.v ? 4'(1 << m_own[u]) : 4'd0;
        return e;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_own[u] = -1; m_ptr[u] = 0; m_held[u] = 0;
        end
    endtask

    // Owner-level behaviour: who holds the resource, for how many cycles, and who is next.
    task automatic model_step(input int u, input logic [3:0] r, input logic d, input int mh);
        bit found;
        if (m_own[u] < 0) begin
            found = 0;
            for (int i = 0; i < 4; i++) begin
                if (!found && r[(m_ptr[u] + i) % 4]) begin
                    found = 1;
                    m_own[u] = (m_ptr[u] + i) % 4;
                    m_held[u] = 1;
                end
            end
        end else if (!r[m_own[u]] || d || (mh != 0 && m_held[u] == mh)) begin
            m_ptr[u] = (m_own[u] + 1) % 4;
            m_own[u] = -1;
        end else begin
            m_held[u]++;
        end
    endtask

    // One clock: inputs already driven are sampled at the edge; returns at posedge+1.
    task automatic cycle();
        @(posedge clk);
        #1;
        model_step(0, req_a, done_a, MH_A);
        model_step(1, req_b, done_b, MH_B);
        q_a.push_back(model_out(0));
        q_b.push_back(model_out(1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q_a.delete();
        q_b.delete();
        model_reset();
        #1;
        chk("reset_gnt", 32'(gnt_a), 32'd0);
        chk("reset_idx", 32'(idx_a), 32'd0);
        chk("reset_valid", 32'(v_a), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    int wait_cnt[4];
    int run_v;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
            run_v = 0;
        end else begin
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk("sb_a_gnt", 32'(gnt_a), 32'(e.gnt));
                chk("sb_a_valid", 32'(v_a), 32'(e.v));
                if (e.v) chk("sb_a_idx", 32'(idx_a), 32'(e.idx));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                chk("sb_b_gnt", 32'(gnt_b), 32'(e.gnt));
                chk("sb_b_valid", 32'(v_b), 32'(e.v));
                if (e.v) chk("sb_b_idx", 32'(idx_b), 32'(e.idx));
            end
            chk("inv_a_onehot", 32'(gnt_a), v_a ? 32'(1 << idx_a) : 32'd0);
            chk("inv_b_onehot", 32'(gnt_b), v_b ? 32'(1 << idx_b) : 32'd0);
            run_v = v_a ? run_v + 1 : 0;
            if (v_a) chk("max_hold_run", 32'(run_v <= MH_A), 32'd1);
            // Bound includes the arbitration cycle in which the requester first lost.
            for (int i = 0; i < 4; i++) begin
                wait_cnt[i] = (req_a[i] && !gnt_a[i]) ? wait_cnt[i] + 1 : 0;
                if (wait_cnt[i] > 3 * (MH_A + 1) + 1) begin
                    chk("starvation", 32'(wait_cnt[i]), 32'(3 * (MH_A + 1) + 1));
                    wait_cnt[i] = 0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // All four requesting with MAX_HOLD=4: full rotation then wrap to 0.
        req_a = 4'b1111;
        for (int o = 0; o < 4; o++) begin
            for (int k = 0; k < 4; k++) begin
                cycle();
                chk("rot_gnt", 32'(gnt_a), 32'(1 << o));
            end
            cycle();
            chk("rot_idle", 32'(gnt_a), 32'd0);
        end
        cycle();
        chk("rot_wrap", 32'(gnt_a), 32'b0001);
        req_a = 4'b0000;
        cycle();
        cycle();

        // Single requester then release by dropping req.
        do_reset();
        req_a = 4'b0100;
        cycle();
        chk("single_gnt", 32'(gnt_a), 32'b0100);
        chk("single_idx", 32'(idx_a), 32'd2);
        chk("single_valid", 32'(v_a), 32'd1);
        req_a = 4'b0000;
        cycle();
        chk("drop_release", 32'(gnt_a), 32'd0);
        req_a = 4'b1001;
        cycle();
        chk("ptr_after_2", 32'(gnt_a), 32'b1000);
        req_a = 4'b0000;
        cycle();
        cycle();

        // done pulse on owner 1's second grant cycle.
        do_reset();
        req_a = 4'b0001;
        cycle();
        req_a = 4'b0000;
        cycle();
        req_a = 4'b0011;
        cycle();
        chk("done_owner1", 32'(gnt_a), 32'b0010);
        cycle();
        chk("done_hold", 32'(gnt_a), 32'b0010);
        done_a = 1'b1;
        cycle();
        done_a = 1'b0;
        chk("done_release", 32'(gnt_a), 32'd0);
        cycle();
        chk("done_wrap0", 32'(gnt_a), 32'b0001);
        req_a = 4'b0000;
        cycle();
        cycle();

        // Asynchronous reset mid-grant.
        req_a = 4'b1000;
        cycle();
        cycle();
        chk("pre_async_gnt", 32'(gnt_a), 32'b1000);
        #2;
        rst_n = 1'b0;
        q_a.delete();
        q_b.delete();
        model_reset();
        #1;
        chk("async_gnt", 32'(gnt_a), 32'd0);
        chk("async_idx", 32'(idx_a), 32'd0);
        chk("async_valid", 32'(v_a), 32'd0);
        req_a = 4'b1001;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cycle();
        chk("post_reset_gnt", 32'(gnt_a), 32'b0001);
        req_a = 4'b0000;
        cycle();
        cycle();

        // Unlimited hold on the second instance.
        do_reset();
        req_b = 4'b0001;
        for (int k = 0; k < 40; k++) begin
            if (k == 20) req_b = 4'b1001;
            cycle();
            chk("unlim_hold", 32'(gnt_b), 32'b0001);
        end
        req_b = 4'b1000;
        cycle();
        chk("unlim_release", 32'(gnt_b), 32'd0);
        cycle();
        chk("unlim_next3", 32'(gnt_b), 32'b1000);
        req_b = 4'b0000;
        cycle();

        // Random sticky requests with occasional done pulses.
        do_reset();
        for (int k = 0; k < 10000; k++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) req_a[i] = ~req_a[i];
            done_a = ($urandom_range(0, 15) == 0);
            req_b = 4'($urandom_range(0, 15));
            done_b = ($urandom_range(0, 15) == 0);
            cycle();
        end
        req_a = '0; done_a = 1'b0; req_b = '0; done_b = 1'b0;
        cycle();
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
